// File: rtl/cache_axi_master_if.sv
// AXI4 bus bundle between the cache write-back/fill engine and the memory fabric.
// Only the channel signals that vary per beat are carried; burst attributes are tied off by the wrapper.
interface cache_axi_master_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  logic [ADDR_SIZE-1:0] awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_SIZE-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_SIZE-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/cache_axi_master.sv
// Cache-side block engine: turns one block request at a time into an AXI4 INCR
// write-back burst or line-fill burst, staging the block in a local buffer.
module cache_axi_master #(
  parameter  int ADDR_SIZE  = 32,
  parameter  int DATA_SIZE  = 32,
  parameter  int BLOCK_SIZE = 6,
  localparam int BLOCKS     = 2 ** BLOCK_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          addr_valid_in,
  input  logic [ADDR_SIZE-1:0]          addr_in,
  input  logic                          rw_in,
  input  logic                          valid_wb,
  output logic                          ready_wb,
  input  logic [BLOCKS*DATA_SIZE-1:0]   data_wb,
  output logic                          valid_ld,
  input  logic                          ready_ld,
  output logic [BLOCKS*DATA_SIZE-1:0]   data_ld,
  cache_axi_master_if.master            m,
  output logic                          bus_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WB_CAP, S_AW, S_W, S_B, S_AR, S_R, S_LD, S_DROP
  } state_t;

  localparam logic [BLOCK_SIZE-1:0] LAST_BEAT = BLOCK_SIZE'(BLOCKS - 1);

  state_t                state_q, state_d;
  logic [BLOCK_SIZE-1:0] cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_SIZE-1:0]  blk_q [BLOCKS];
  logic [DATA_SIZE-1:0]  blk_d [BLOCKS];
  logic [DATA_SIZE-1:0]  wb_words [BLOCKS];

  genvar gi;
  generate
    for (gi = 0; gi < BLOCKS; gi++) begin : g_unpack
      assign wb_words[gi] = data_wb[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  always_comb begin
    data_ld = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      data_ld[i*DATA_SIZE +: DATA_SIZE] = blk_q[i];
    end
  end

  assign m.awaddr = addr_q;
  assign m.araddr = addr_q;
  assign m.wdata  = blk_q[cnt_q];
  assign bus_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // The block buffer deliberately survives reset.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    blk_d     = blk_q;
    ready_wb  = 1'b0;
    valid_ld  = 1'b0;
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.wlast   = 1'b0;
    m.bready  = 1'b0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (addr_valid_in) begin
          addr_d  = {addr_in[ADDR_SIZE-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
          state_d = rw_in ? S_WB_CAP : S_AR;
        end
      end
      S_WB_CAP: begin
        if (valid_wb) begin
          ready_wb = 1'b1;
          blk_d    = wb_words;
          state_d  = S_AW;
        end
      end
      S_AW: begin
        m.awvalid = 1'b1;
        if (m.awready) begin
          cnt_d   = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        m.wvalid = 1'b1;
        m.wlast  = (cnt_q == LAST_BEAT);
        if (m.wready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_B: begin
        m.bready = 1'b1;
        if (m.bvalid) begin
          if (m.bresp != 2'b00) err_d = 1'b1;
          state_d = S_DROP;
        end
      end
      S_AR: begin
        m.arvalid = 1'b1;
        if (m.arready) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_R;
        end
      end
      S_R: begin
        m.rready = 1'b1;
        if (m.rvalid) begin
          if (m.rresp != 2'b00) err_d = 1'b1;
          if (!ovf_q) blk_d[cnt_q] = m.rdata;
          // Short bursts flag an error; overlong bursts are drained after the last slot fills.
          if (m.rlast) begin
            if (!ovf_q && cnt_q != LAST_BEAT) err_d = 1'b1;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_LD;
          end else if (!ovf_q) begin
            if (cnt_q == LAST_BEAT) begin
              ovf_d = 1'b1;
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_LD: begin
        valid_ld = 1'b1;
        if (ready_ld) state_d = S_DROP;
      end
      S_DROP: begin
        if (!addr_valid_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_axi_master.sv
// Randomized self-checking bench: a behavioural AXI slave and a block-level model of
// expected beats, fill data and the sticky error flag.
module tb_cache_axi_master;
  localparam int A = 32;
  localparam int D = 32;
  localparam int B = 6;
  localparam int N = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           addr_valid_in;
  logic [A-1:0]   addr_in;
  logic           rw_in;
  logic           valid_wb;
  logic           ready_wb;
  logic [N*D-1:0] data_wb;
  logic           valid_ld;
  logic           ready_ld;
  logic [N*D-1:0] data_ld;
  logic           bus_err;

  cache_axi_master_if #(.ADDR_SIZE(A), .DATA_SIZE(D)) axi ();

  cache_axi_master #(.ADDR_SIZE(A), .DATA_SIZE(D), .BLOCK_SIZE(B)) dut (
    .clk(clk), .rst_n(rst_n), .addr_valid_in(addr_valid_in), .addr_in(addr_in), .rw_in(rw_in),
    .valid_wb(valid_wb), .ready_wb(ready_wb), .data_wb(data_wb),
    .valid_ld(valid_ld), .ready_ld(ready_ld), .data_ld(data_ld),
    .m(axi), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected block contents and sticky error.
  logic [D-1:0] mbuf [N];
  logic         exp_err;

  // Bus monitor.
  int           ar_hs, aw_hs, b_hs, w_early;
  logic [D-1:0] wq [$];
  logic         wl [$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (axi.wvalid && aw_hs == 0) w_early++;
      if (axi.arvalid && axi.arready) ar_hs++;
      if (axi.awvalid && axi.awready) aw_hs++;
      if (axi.wvalid && axi.wready) begin
        wq.push_back(axi.wdata);
        wl.push_back(axi.wlast);
      end
      if (axi.bvalid && axi.bready) b_hs++;
    end
  end

  // Observations filled by the drivers.
  logic         obs_tmo, obs_stable_ok, obs_lat_ok, obs_hold_ok, obs_after_ok, obs_rready_ok;
  logic         obs_pulse_ok, obs_bready_ok, obs_reset_hit;
  int           obs_ar_lat;
  logic [N*D-1:0] obs_data;

  task automatic clr_mon();
    ar_hs = 0; aw_hs = 0; b_hs = 0; w_early = 0;
    wq.delete(); wl.delete();
    obs_tmo = 0; obs_stable_ok = 1; obs_lat_ok = 1; obs_hold_ok = 1; obs_after_ok = 1;
    obs_rready_ok = 1; obs_pulse_ok = 1; obs_bready_ok = 1; obs_reset_hit = 0; obs_ar_lat = -1;
  endtask

  task automatic idle_inputs();
    addr_valid_in = 0; addr_in = '0; rw_in = 0; valid_wb = 0; ready_ld = 0;
    axi.awready = 0; axi.wready = 0; axi.bresp = 2'b00; axi.bvalid = 0;
    axi.arready = 0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 0; axi.rvalid = 0;
  endtask

  task automatic run_load(input logic [A-1:0] addr, input int ar_delay, input int last_beat,
                          input int bad_beat, input int hold);
    logic [A-1:0] exp_addr;
    logic [D-1:0] d;
    int n;
    exp_addr = {addr[A-1:B], {B{1'b0}}};
    @(negedge clk);
    addr_valid_in = 1; addr_in = addr; rw_in = 0;
    @(negedge clk);
    n = 0;
    while (!axi.arvalid && n < 100) begin @(negedge clk); n++; end
    obs_ar_lat = n;
    if (n >= 100) begin obs_tmo = 1; return; end
    for (int k = 0; k < ar_delay; k++) begin
      if (!axi.arvalid || axi.araddr !== exp_addr) obs_stable_ok = 0;
      @(negedge clk);
    end
    if (!axi.arvalid || axi.araddr !== exp_addr) obs_stable_ok = 0;
    axi.arready = 1;
    @(negedge clk);
    axi.arready = 0;
    for (int b = 0; b <= last_beat; b++) begin
      while ($urandom_range(0, 3) == 0) @(negedge clk);
      if (!axi.rready) obs_rready_ok = 0;
      d = $urandom;
      axi.rvalid = 1; axi.rdata = d; axi.rlast = (b == last_beat);
      axi.rresp = (b == bad_beat) ? 2'b10 : 2'b00;
      if (b < N) mbuf[b] = d;
      @(negedge clk);
      axi.rvalid = 0; axi.rlast = 0; axi.rresp = 2'b00;
    end
    if (last_beat != N - 1 || (bad_beat >= 0 && bad_beat <= last_beat)) exp_err = 1;
    obs_lat_ok = valid_ld;
    n = 0;
    while (!valid_ld && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin obs_tmo = 1; return; end
    for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
      if (!valid_ld) obs_hold_ok = 0;
      @(negedge clk);
    end
    if (!valid_ld) obs_hold_ok = 0;
    ready_ld = 1; obs_data = data_ld;
    @(negedge clk);
    ready_ld = 0;
    if (valid_ld) obs_after_ok = 0;
    for (int k = 0; k < hold; k++) @(negedge clk);
    addr_valid_in = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_wb(input logic [A-1:0] addr, input int aw_delay, input logic [1:0] bresp,
                        input int reset_at);
    logic [A-1:0] exp_addr;
    int n;
    exp_addr = {addr[A-1:B], {B{1'b0}}};
    @(negedge clk);
    addr_valid_in = 1; addr_in = addr; rw_in = 1; valid_wb = 0;
    for (int i = 0; i < N; i++) data_wb[i*D +: D] = mbuf[i];
    repeat ($urandom_range(0, 3)) @(negedge clk);
    valid_wb = 1;
    #1;
    n = 0;
    while (!ready_wb && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) begin obs_tmo = 1; return; end
    @(negedge clk);
    if (ready_wb) obs_pulse_ok = 0;
    valid_wb = 0;
    for (int i = 0; i < N; i++) data_wb[i*D +: D] = $urandom;
    n = 0;
    while (!axi.awvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin obs_tmo = 1; return; end
    for (int k = 0; k < aw_delay; k++) begin
      if (!axi.awvalid || axi.awaddr !== exp_addr) obs_stable_ok = 0;
      @(negedge clk);
    end
    if (!axi.awvalid || axi.awaddr !== exp_addr) obs_stable_ok = 0;
    axi.awready = 1;
    @(negedge clk);
    axi.awready = 0;
    n = 0;
    while (wq.size() < N && n < 2000) begin
      if (reset_at >= 0 && wq.size() == reset_at) begin
        axi.wready = 0; rst_n = 0; obs_reset_hit = 1;
        #1;
        return;
      end
      axi.wready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    axi.wready = 0;
    if (n >= 2000) begin obs_tmo = 1; return; end
    obs_bready_ok = axi.bready;
    axi.bvalid = 1; axi.bresp = bresp;
    @(negedge clk);
    axi.bvalid = 0; axi.bresp = 2'b00;
    if (bresp != 2'b00) exp_err = 1;
    addr_valid_in = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; exp_err = 0;
    clr_mon();
    repeat (2) @(negedge clk);
    checks++;
    if ({ready_wb, valid_ld, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid,
         axi.rready, bus_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {ready_wb, valid_ld, axi.awvalid, axi.wvalid,
               axi.wlast, axi.bready, axi.arvalid, axi.rready, bus_err});
    end
    checks++;
    if (axi.awaddr !== 32'h0 || axi.araddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got aw=%h ar=%h expected 0", axi.awaddr, axi.araddr);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_basic(input string tag);
    clr_mon();
    run_load(32'h0000_1234, 3, N - 1, -1, 0);
    checks++;
    if (obs_tmo) begin errors++; $display("FAIL %s_timeout: got timeout expected completion", tag); end
    checks++;
    if (obs_ar_lat !== 0) begin errors++; $display("FAIL %s_ar_latency: got %0d expected 0", tag, obs_ar_lat); end
    checks++;
    if (!obs_stable_ok) begin errors++; $display("FAIL %s_araddr: got unstable expected 00001200", tag); end
    checks++;
    if (!obs_lat_ok || !obs_hold_ok || !obs_after_ok) begin
      errors++;
      $display("FAIL %s_valid_ld: got lat=%b hold=%b drop=%b expected 111", tag, obs_lat_ok, obs_hold_ok, obs_after_ok);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_data[i*D +: D] !== mbuf[i]) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h expected %h", tag, i, obs_data[i*D +: D], mbuf[i]);
      end
    end
    checks++;
    if (ar_hs !== 1 || bus_err !== exp_err) begin
      errors++;
      $display("FAIL %s_status: got ar=%0d err=%b expected ar=1 err=%b", tag, ar_hs, bus_err, exp_err);
    end
    $display("load %s addr=00001234 ar=%0d err=%b", tag, ar_hs, bus_err);
  endtask

  task automatic check_wb(input string tag);
    checks++;
    if (obs_tmo) begin errors++; $display("FAIL %s_timeout: got timeout expected completion", tag); end
    checks++;
    if (wq.size() !== N) begin errors++; $display("FAIL %s_beats: got %0d expected %0d", tag, wq.size(), N); end
    for (int i = 0; i < N && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== mbuf[i] || wl[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL %s_beat[%0d]: got %h last=%b expected %h last=%b", tag, i, wq[i], wl[i], mbuf[i], i == N - 1);
      end
    end
    checks++;
    if (aw_hs !== 1 || b_hs !== 1 || w_early !== 0 || !obs_stable_ok || !obs_pulse_ok || !obs_bready_ok) begin
      errors++;
      $display("FAIL %s_protocol: got aw=%0d b=%0d early=%0d stable=%b pulse=%b bready=%b expected 1 1 0 1 1 1",
               tag, aw_hs, b_hs, w_early, obs_stable_ok, obs_pulse_ok, obs_bready_ok);
    end
    checks++;
    if (bus_err !== exp_err) begin errors++; $display("FAIL %s_bus_err: got %b expected %b", tag, bus_err, exp_err); end
    $display("writeback %s beats=%0d err=%b", tag, wq.size(), bus_err);
  endtask

  task automatic test_writeback();
    clr_mon();
    for (int i = 0; i < N; i++) mbuf[i] = 32'hA000_0000 + i;
    run_wb(32'h0000_5678, 2, 2'b00, -1);
    check_wb("wb");
  endtask

  task automatic test_short_rlast();
    clr_mon();
    run_load($urandom, 1, 31, -1, 0);
    checks++;
    if (obs_tmo || !obs_lat_ok) begin errors++; $display("FAIL short_valid_ld: got tmo=%b lat=%b expected 0 1", obs_tmo, obs_lat_ok); end
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL short_bus_err: got %b expected 1", bus_err); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_data[i*D +: D] !== mbuf[i]) begin
        errors++;
        $display("FAIL short_data[%0d]: got %h expected %h", i, obs_data[i*D +: D], mbuf[i]);
      end
    end
    clr_mon();
    run_load(32'h0000_1234, 0, N - 1, -1, 0);
    checks++;
    if (obs_tmo || ar_hs !== 1) begin errors++; $display("FAIL short_back_to_idle: got ar=%0d tmo=%b expected 1 0", ar_hs, obs_tmo); end
    $display("short_rlast beats=32 err=%b", bus_err);
  endtask

  task automatic test_long_burst();
    clr_mon();
    run_load($urandom, 0, 70, -1, 0);
    checks++;
    if (obs_tmo || !obs_rready_ok || bus_err !== 1'b1) begin
      errors++;
      $display("FAIL long_burst: got tmo=%b rready=%b err=%b expected 0 1 1", obs_tmo, obs_rready_ok, bus_err);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_data[i*D +: D] !== mbuf[i]) begin
        errors++;
        $display("FAIL long_data[%0d]: got %h expected %h", i, obs_data[i*D +: D], mbuf[i]);
      end
    end
    $display("long_burst beats=71 err=%b", bus_err);
  endtask

  task automatic test_reset_mid_burst();
    clr_mon();
    for (int i = 0; i < N; i++) mbuf[i] = $urandom;
    run_wb(32'h0000_9000, 0, 2'b00, 10);
    checks++;
    if (!obs_reset_hit) begin errors++; $display("FAIL midrst_reach: got %0d beats expected 10", wq.size()); end
    checks++;
    if ({ready_wb, valid_ld, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready,
         bus_err} !== 9'b0 || axi.awaddr !== 32'h0 || axi.araddr !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got ctrl=%b aw=%h ar=%h expected 0", {ready_wb, valid_ld, axi.awvalid,
               axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready, bus_err}, axi.awaddr, axi.araddr);
    end
    $display("reset_mid_burst beats_before=%0d", wq.size());
    idle_inputs();
    exp_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    test_load_basic("after_rst");
  endtask

  task automatic test_hold_request();
    clr_mon();
    run_load($urandom, $urandom_range(0, 3), N - 1, -1, 20);
    checks++;
    if (obs_tmo || ar_hs !== 1) begin errors++; $display("FAIL hold_single_ar: got %0d expected 1", ar_hs); end
    $display("hold_request ar=%0d", ar_hs);
  endtask

  task automatic test_err_sticky();
    clr_mon();
    for (int i = 0; i < N; i++) mbuf[i] = 32'hA000_0000 + i;
    run_wb(32'h0000_5678, 2, 2'b10, -1);
    check_wb("wb_err");
    test_load_basic("after_err");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      clr_mon();
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < N; i++) mbuf[i] = $urandom;
        run_wb($urandom, $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, -1);
        check_wb("rand_wb");
      end else begin
        run_load($urandom, $urandom_range(0, 4), N - 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1, 0);
        checks++;
        if (obs_tmo || ar_hs !== 1 || bus_err !== exp_err) begin
          errors++;
          $display("FAIL rand_ld_status: got tmo=%b ar=%0d err=%b expected 0 1 %b", obs_tmo, ar_hs, bus_err, exp_err);
        end
        for (int i = 0; i < N; i++) begin
          checks++;
          if (obs_data[i*D +: D] !== mbuf[i]) begin
            errors++;
            $display("FAIL rand_ld_data[%0d]: got %h expected %h", i, obs_data[i*D +: D], mbuf[i]);
          end
        end
        $display("load rand err=%b", bus_err);
      end
    end
  endtask

  initial begin
    data_wb = '0;
    test_reset();
    test_load_basic("basic");
    test_writeback();
    test_short_rlast();
    test_reset_mid_burst();
    test_hold_request();
    test_long_burst();
    test_reset();
    test_err_sticky();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
